// File: rtl/ahb_dm_pkg.sv
// Shared types and constants for the AHB-Lite to debug-module memory bridge.
package ahb_dm_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  localparam logic [2:0] SizeByte  = 3'd0;
  localparam logic [2:0] SizeHalf  = 3'd1;
  localparam logic [2:0] SizeWord  = 3'd2;
  localparam logic [2:0] SizeDword = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StResp,
    StDone,
    StErr1,
    StErr2
  } state_e;

  localparam logic RespOkay  = 1'b0;
  localparam logic RespError = 1'b1;

endpackage

// File: rtl/ahb_dm_be_gen.sv
// Byte-enable generator: lane offset + HSIZE -> byte enables, plus an illegal flag for
// oversized or misaligned accesses.
module ahb_dm_be_gen #(
  parameter int unsigned HDATA_SIZE = 32,
  localparam int unsigned Bytes     = HDATA_SIZE / 8,
  localparam int unsigned OffW      = $clog2(Bytes)
) (
  input  logic [OffW-1:0]  addr_i,
  input  logic [2:0]       size_i,
  output logic [Bytes-1:0] be_o,
  output logic             illegal_o
);

  int unsigned nbytes;
  int unsigned off;

  always_comb begin
    be_o      = '0;
    illegal_o = 1'b0;
    off       = 32'(addr_i);
    nbytes    = 32'd1 << size_i;
    if (32'(size_i) > OffW) begin
      illegal_o = 1'b1;
    end else if ((off & (nbytes - 32'd1)) != 32'd0) begin
      illegal_o = 1'b1;
    end else begin
      for (int unsigned i = 0; i < Bytes; i++) begin
        be_o[i] = (i >= off) && (i < off + nbytes);
      end
    end
  end

endmodule

// File: rtl/ahb_dm_bridge.sv
// AHB-Lite slave bridging onto the debug-module req/gnt/rvalid memory port.
// Optional response timeout enabled by defining AHB_DM_TIMEOUT_EN.
module ahb_dm_bridge
  import ahb_dm_pkg::*;
#(
  parameter int unsigned HADDR_SIZE     = 32,
  parameter int unsigned HDATA_SIZE     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned Bytes         = HDATA_SIZE / 8,
  localparam int unsigned OffW          = $clog2(Bytes)
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  dm_req_o,
  output logic [HADDR_SIZE-1:0] dm_addr_o,
  output logic                  dm_we_o,
  output logic [Bytes-1:0]      dm_be_o,
  output logic [HDATA_SIZE-1:0] dm_wdata_o,
  input  logic [HDATA_SIZE-1:0] dm_rdata_i,
  input  logic                  dm_rvalid_i,
  input  logic                  dm_gnt_i
);

  state_e                  state_q, state_d;
  logic [HADDR_SIZE-1:0]   addr_q;
  logic                    we_q;
  logic [Bytes-1:0]        be_q;
  logic [HDATA_SIZE-1:0]   rdata_q;
  logic [Bytes-1:0]        be;
  logic                    illegal;
  logic                    accept;
  logic                    can_accept;
  logic                    timeout;
  htrans_t                 trans;

  // Bursts and protection attributes do not affect the DM access.
  logic unused_ahb;
  assign unused_ahb = ^{HBURST, HPROT, 32'(TIMEOUT_CYCLES)};

  ahb_dm_be_gen #(
    .HDATA_SIZE(HDATA_SIZE)
  ) u_be_gen (
    .addr_i   (HADDR[OffW-1:0]),
    .size_i   (HSIZE),
    .be_o     (be),
    .illegal_o(illegal)
  );

  assign trans      = htrans_t'(HTRANS);
  assign accept     = HSEL && HREADY && (trans == TransNonseq || trans == TransSeq);
  assign can_accept = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr2);

`ifdef AHB_DM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter is held at zero outside REQ/RESP so every request starts from zero.
  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if (state_q == StReq || state_q == StResp) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CntW'(TIMEOUT_CYCLES - 1) && !(state_q == StResp && dm_rvalid_i)) begin
        timeout = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr2: begin
        if (accept) state_d = illegal ? StErr1 : StReq;
        else        state_d = StIdle;
      end
      StReq:   if (dm_gnt_i) state_d = StResp;
      StResp:  if (dm_rvalid_i) state_d = StDone;
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
    if (timeout) state_d = StErr1;
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = RespOkay;
    case (state_q)
      StReq, StResp: HREADYOUT = 1'b0;
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = RespError;
      end
      StErr2:  HRESP = RespError;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && can_accept && !illegal) begin
        addr_q <= {HADDR[HADDR_SIZE-1:OffW], OffW'(0)};
        we_q   <= HWRITE;
        be_q   <= be;
      end
      if (state_q == StResp && dm_rvalid_i && !we_q && !timeout) begin
        rdata_q <= dm_rdata_i;
      end
    end
  end

  assign dm_req_o   = (state_q == StReq) && !timeout;
  assign dm_addr_o  = addr_q;
  assign dm_we_o    = we_q;
  assign dm_be_o    = be_q;
  assign dm_wdata_o = HWDATA;
  assign HRDATA     = rdata_q;

endmodule

// File: tb/tb_ahb_dm_bridge.sv
// Scoreboard bench for ahb_dm_bridge: an AHB driver, a DM responder, and two monitors
// (AHB response side, DM request side) popping expected items from queues.
module tb_ahb_dm_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic        dm_req_o;
  logic [31:0] dm_addr_o;
  logic        dm_we_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_wdata_o;
  logic [31:0] dm_rdata_i;
  logic        dm_rvalid_i;
  logic        dm_gnt_i;

  assign HREADY = HREADYOUT;

  ahb_dm_bridge #(
    .HADDR_SIZE    (32),
    .HDATA_SIZE    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HPROT      (HPROT),
    .HTRANS     (HTRANS),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .dm_req_o   (dm_req_o),
    .dm_addr_o  (dm_addr_o),
    .dm_we_o    (dm_we_o),
    .dm_be_o    (dm_be_o),
    .dm_wdata_o (dm_wdata_o),
    .dm_rdata_i (dm_rdata_i),
    .dm_rvalid_i(dm_rvalid_i),
    .dm_gnt_i   (dm_gnt_i)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          hold;
  } dm_exp_t;

  typedef struct {
    int          gnt_delay;
    bit          rvalid;
    logic [31:0] rdata;
  } dm_cfg_t;

  rsp_exp_t rsp_q[$];
  dm_exp_t  dm_q[$];
  dm_cfg_t  cfg_q[$];

  int checks = 0;
  int errors = 0;
  int stray_req = 0;
  logic [31:0] model_rdata;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // DM responder: grants after a per-request delay, returns rvalid the cycle after grant.
  dm_cfg_t cur;
  bit      active = 0;
  bit      req_prev = 0;
  int      wait_n = 0;
  int      stray_done = 0;

  initial begin
    dm_gnt_i    = 1'b0;
    dm_rvalid_i = 1'b0;
    dm_rdata_i  = '0;
  end

  always @(posedge HCLK) begin
    bit hs;
    #1;
    hs          = req_prev && dm_gnt_i;
    dm_rvalid_i = 1'b0;
    dm_rdata_i  = '0;
    if (hs && cur.rvalid) begin
      dm_rvalid_i = 1'b1;
      dm_rdata_i  = cur.rdata;
    end else if (stray_done != stray_req) begin
      dm_rvalid_i = 1'b1;
      dm_rdata_i  = 32'h5555_5555;
      stray_done++;
    end
    if (dm_req_o && !HRESET) begin
      if (!active || hs) begin
        active = 1;
        wait_n = 0;
        if (cfg_q.size() > 0) cur = cfg_q.pop_front();
        else cur = '{gnt_delay: 0, rvalid: 1'b1, rdata: 32'h0};
      end
      dm_gnt_i = (wait_n == cur.gnt_delay);
      wait_n++;
    end else begin
      dm_gnt_i = 1'b0;
      active   = 0;
    end
    req_prev = dm_req_o;
  end

  // DM-side monitor: checks every granted request against the expected access.
  int hold = 0;
  always @(negedge HCLK) begin
    dm_exp_t e;
    if (HRESET) begin
      hold = 0;
    end else if (dm_req_o) begin
      hold++;
      if (dm_gnt_i) begin
        if (dm_q.size() == 0) begin
          chk("dm_unexpected_req", {32'h0, dm_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = dm_q.pop_front();
          chk("dm_addr", 64'(dm_addr_o), 64'(e.addr));
          chk("dm_be", 64'(dm_be_o), 64'(e.be));
          chk("dm_we", 64'(dm_we_o), 64'(e.we));
          if (e.we) chk("dm_wdata", 64'(dm_wdata_o), 64'(e.wdata));
          chk("dm_req_hold", 64'(hold), 64'(e.hold));
        end
        hold = 0;
      end
    end
  end

  // AHB response monitor: a data phase ends when HREADYOUT is high.
  bit   pending = 0;
  int   waits = 0;
  logic last_wait_resp = 1'b0;
  always @(negedge HCLK) begin
    rsp_exp_t e;
    if (HRESET) begin
      pending = 0;
      waits   = 0;
    end else if (!HREADYOUT) begin
      if (pending) begin
        waits++;
        last_wait_resp = HRESP;
      end
    end else begin
      if (pending) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(HRDATA), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = rsp_q.pop_front();
          chk("hresp", 64'(HRESP), 64'(e.err));
          chk("hrdata", 64'(HRDATA), 64'(e.rdata));
          chk("wait_states", 64'(waits), 64'(e.waits));
          if (e.waits > 0) chk("hresp_last_wait", 64'(last_wait_resp), 64'(e.err));
        end
      end
      pending        = HSEL && HTRANS[1];
      waits          = 0;
      last_wait_resp = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_ready();
    bit rdy = 0;
    int n = 0;
    while (!rdy && n < 50) begin
      @(negedge HCLK);
      rdy = HREADYOUT;
      cyc();
      n++;
    end
    if (!rdy) chk("ready_timeout", 64'(rdy), 64'd1);
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = sz;
    wait_ready();
  endtask

  task automatic go_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = 3'd0; HPROT = 4'd0; HTRANS = 2'b00;
    model_rdata = '0;
    repeat (3) cyc();
    chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("rst_hresp", 64'(HRESP), 64'd0);
    chk("rst_hrdata", 64'(HRDATA), 64'd0);
    chk("rst_dm_req", 64'(dm_req_o), 64'd0);
    chk("rst_dm_we", 64'(dm_we_o), 64'd0);
    chk("rst_dm_be", 64'(dm_be_o), 64'd0);
    chk("rst_dm_addr", 64'(dm_addr_o), 64'd0);
    HRESET = 1'b0;
    cyc();

    // Word read, minimum latency
    cfg_q.push_back('{gnt_delay: 0, rvalid: 1'b1, rdata: 32'hDEAD_BEEF});
    dm_q.push_back('{addr: 32'h100, be: 4'hF, we: 1'b0, wdata: 32'h0, hold: 1});
    rsp_q.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF, waits: 2});
    addr_phase(32'h100, 1'b0, 3'd2);
    go_idle();
    wait_ready();
    model_rdata = 32'hDEAD_BEEF;

    // Byte write to lane 3; the DM's rdata must not be captured
    cfg_q.push_back('{gnt_delay: 0, rvalid: 1'b1, rdata: 32'h1234_5678});
    dm_q.push_back('{addr: 32'h200, be: 4'b1000, we: 1'b1, wdata: 32'hAB00_0000, hold: 1});
    rsp_q.push_back('{err: 1'b0, rdata: model_rdata, waits: 2});
    addr_phase(32'h203, 1'b1, 3'd0);
    HWDATA = 32'hAB00_0000;
    go_idle();
    wait_ready();

    // Stray rvalid while idle is ignored
    stray_req++;
    repeat (3) cyc();
    chk("idle_stray_hrdata", 64'(HRDATA), 64'(model_rdata));

    // Misaligned halfword and oversized dword: two-cycle error, no DM request
    rsp_q.push_back('{err: 1'b1, rdata: model_rdata, waits: 1});
    addr_phase(32'h101, 1'b0, 3'd1);
    go_idle();
    wait_ready();
    rsp_q.push_back('{err: 1'b1, rdata: model_rdata, waits: 1});
    addr_phase(32'h108, 1'b0, 3'd3);
    go_idle();
    wait_ready();

    // Pipelined: read, read with delayed grant, halfword write at upper lanes
    cfg_q.push_back('{gnt_delay: 0, rvalid: 1'b1, rdata: 32'h1111_1111});
    cfg_q.push_back('{gnt_delay: 2, rvalid: 1'b1, rdata: 32'h2222_2222});
    cfg_q.push_back('{gnt_delay: 0, rvalid: 1'b1, rdata: 32'h3333_3333});
    dm_q.push_back('{addr: 32'h300, be: 4'hF, we: 1'b0, wdata: 32'h0, hold: 1});
    dm_q.push_back('{addr: 32'h304, be: 4'hF, we: 1'b0, wdata: 32'h0, hold: 3});
    dm_q.push_back('{addr: 32'h300, be: 4'b1100, we: 1'b1, wdata: 32'hBEEF_0000, hold: 1});
    rsp_q.push_back('{err: 1'b0, rdata: 32'h1111_1111, waits: 2});
    rsp_q.push_back('{err: 1'b0, rdata: 32'h2222_2222, waits: 4});
    rsp_q.push_back('{err: 1'b0, rdata: 32'h2222_2222, waits: 2});
    addr_phase(32'h300, 1'b0, 3'd2);
    HWDATA = 32'h0;
    addr_phase(32'h304, 1'b0, 3'd2);
    HWDATA = 32'h0;
    addr_phase(32'h302, 1'b1, 3'd1);
    HWDATA = 32'hBEEF_0000;
    go_idle();
    wait_ready();
    model_rdata = 32'h2222_2222;

`ifdef AHB_DM_TIMEOUT_EN
    // Granted but never answered: error after REQ + 7 RESP cycles + ERR1
    cfg_q.push_back('{gnt_delay: 0, rvalid: 1'b0, rdata: 32'h0});
    dm_q.push_back('{addr: 32'h400, be: 4'hF, we: 1'b0, wdata: 32'h0, hold: 1});
    rsp_q.push_back('{err: 1'b1, rdata: model_rdata, waits: 9});
    addr_phase(32'h400, 1'b0, 3'd2);
    go_idle();
    wait_ready();
    stray_req++;
    repeat (3) cyc();
    chk("late_rvalid_hrdata", 64'(HRDATA), 64'(model_rdata));
`endif

    // Reset while waiting in RESP, then a normal transfer
    cfg_q.push_back('{gnt_delay: 0, rvalid: 1'b0, rdata: 32'h0});
    dm_q.push_back('{addr: 32'h500, be: 4'hF, we: 1'b0, wdata: 32'h0, hold: 1});
    addr_phase(32'h500, 1'b0, 3'd2);
    go_idle();
    cyc();
    HRESET = 1'b1;
    cyc();
    chk("midrst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("midrst_dm_req", 64'(dm_req_o), 64'd0);
    chk("midrst_hrdata", 64'(HRDATA), 64'd0);
    HRESET = 1'b0;
    model_rdata = '0;
    cyc();
    cfg_q.push_back('{gnt_delay: 0, rvalid: 1'b1, rdata: 32'hCAFE_F00D});
    dm_q.push_back('{addr: 32'h504, be: 4'hF, we: 1'b0, wdata: 32'h0, hold: 1});
    rsp_q.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D, waits: 2});
    addr_phase(32'h504, 1'b0, 3'd2);
    go_idle();
    wait_ready();

    repeat (4) cyc();
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    chk("dm_queue_drained", 64'(dm_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
